logic_gate_unit_pipe: RTL and testbench



---
 rtl/logic_gate_unit_pipe_pkg.sv | 23 ++
 rtl/logic_gate_unit_pipe_if.sv | 29 ++
 rtl/logic_gate_unit_pipe_gate_bitwise.sv | 28 ++
 rtl/logic_gate_unit_pipe.sv | 106 ++++++++++
 tb/tb_logic_gate_unit_pipe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_gate_unit_pipe_pkg.sv
// Shared types for the bitwise gate unit: operation codes and output buffer occupancy.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/logic_gate_unit_pipe_if.sv
// Operand/result handshake bundle; master is the producer/consumer side, slave is the unit.
interface logic_gate_unit_pipe_if
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones, xfer_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones, xfer_count
  );
endinterface

// File: rtl/logic_gate_unit_pipe_gate_bitwise.sv
// Purely combinational WIDTH-bit gate with run-time operation select.
module gate_bitwise
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit_pipe.sv
// Registered bitwise gate unit: result and flags computed at acceptance, held in a
// 2-entry in-order buffer so the producer sees full throughput under back-pressure.
module logic_gate_unit_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_gate_unit_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] res_p0;
  entry_t           new_p0;
  entry_t           head_p1;
  entry_t           tail_p1;
  buf_state_e       state_q;
  buf_state_e       state_d;
  logic             push;
  logic             pop;
  logic             load_head_new;
  logic             load_head_tail;
  logic             load_tail;
  logic [CNT_W-1:0] cnt_q;

  // Stage p0: combinational gate and flag evaluation on the offered beat
  gate_bitwise #(.WIDTH(WIDTH)) u_gate (
    .a  (bus.a),
    .b  (bus.b),
    .op (op_e'(bus.op)),
    .y  (res_p0)
  );

  assign new_p0 = '{y: res_p0, zero: ~|res_p0, ones: &res_p0};

  assign bus.in_ready  = (state_q != BUF_TWO) && !rst;
  assign bus.out_valid = (state_q != BUF_EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          state_d       = BUF_ONE;
          load_head_new = 1'b1;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_d   = BUF_TWO;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          state_d        = BUF_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Stage p1: buffered entries, occupancy and transfer count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_p1 <= '0;
      tail_p1 <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_head_new)       head_p1 <= new_p0;
      else if (load_head_tail) head_p1 <= tail_p1;
      if (load_tail)           tail_p1 <= new_p0;
      if (push)                cnt_q   <= sat_inc(cnt_q);
    end
  end

  assign bus.y          = head_p1.y;
  assign bus.y_zero     = head_p1.zero;
  assign bus.y_ones     = head_p1.ones;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_logic_gate_unit_pipe.sv
// Directed bench for logic_gate_unit_pipe: op sweep, flags, back-pressure,
// push/pop interleave against a queue model, async reset and counter saturation.
module tb_logic_gate_unit_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic_gate_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  logic_gate_unit_pipe_if #(.WIDTH(8), .CNT_W(3))  bus2 ();

  logic_gate_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic_gate_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gold(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = z;
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] model_q [$];
  logic [7:0] beat_a;
  logic [7:0] beat_b;
  logic [2:0] beat_op;
  int         beat_j;
  int         exp_cnt;
  logic       do_push;
  logic       do_pop;

  initial begin
    total = 0;
    bad   = 0;
    sweep_exp = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.op        = 3'd7;
    bus2.a         = 8'h11;
    bus2.b         = 8'h00;
    bus2.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_y_zero", 32'(bus.y_zero), 32'd0);
    chk("rst_y_ones", 32'(bus.y_ones), 32'd0);
    chk("rst_count", 32'(bus.xfer_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // op sweep, one beat per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("sweep_valid", 32'(bus.out_valid), 32'd1);
        chk($sformatf("sweep_y_op%0d", i - 1), 32'(bus.y), 32'(sweep_exp[i-1]));
        chk("sweep_in_ready", 32'(bus.in_ready), 32'd1);
      end
      if (i < 8) drive(1'b1, 3'(i), 8'hA5, 8'h3C);
      else       drive(1'b0, 3'd0, 8'h00, 8'h00);
    end
    @(negedge clk);
    chk("sweep_drained", 32'(bus.out_valid), 32'd0);
    chk("sweep_count", 32'(bus.xfer_count), 32'd8);

    // flags
    drive(1'b1, 3'd3, 8'hFF, 8'h00);
    @(negedge clk);
    chk("nor_y", 32'(bus.y), 32'h00);
    chk("nor_zero", 32'(bus.y_zero), 32'd1);
    chk("nor_ones", 32'(bus.y_ones), 32'd0);
    drive(1'b1, 3'd2, 8'h00, 8'h00);
    @(negedge clk);
    chk("nand_y", 32'(bus.y), 32'hFF);
    chk("nand_ones", 32'(bus.y_ones), 32'd1);
    chk("nand_zero", 32'(bus.y_zero), 32'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("flags_drained", 32'(bus.out_valid), 32'd0);
    chk("flags_count", 32'(bus.xfer_count), 32'd10);

    // back-pressure: third beat must be held off until space frees
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 8'hF0, 8'hFF);
    @(negedge clk);
    chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp1_y", 32'(bus.y), 32'hF0);
    drive(1'b1, 3'd1, 8'h0F, 8'h30);
    @(negedge clk);
    chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_y", 32'(bus.y), 32'hF0);
    drive(1'b1, 3'd4, 8'hAA, 8'hFF);
    @(negedge clk);
    chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_y_stable", 32'(bus.y), 32'hF0);
    chk("bp3_count", 32'(bus.xfer_count), 32'd12);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp4_y", 32'(bus.y), 32'h3F);
    chk("bp4_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp4_count", 32'(bus.xfer_count), 32'd12);
    @(negedge clk);
    chk("bp5_y", 32'(bus.y), 32'h55);
    chk("bp5_count", 32'(bus.xfer_count), 32'd13);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // interleaved push/pop against a queue model
    exp_cnt = 13;
    beat_j  = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      chk("mix_out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
      chk("mix_in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
      if (model_q.size() > 0) chk($sformatf("mix_y_c%0d", cyc), 32'(bus.y), 32'(model_q[0]));
      beat_op = 3'(beat_j);
      beat_a  = 8'(beat_j * 37 + 1);
      beat_b  = 8'(beat_j * 91 + 7);
      drive(1'b1, beat_op, beat_a, beat_b);
      bus.out_ready = (cyc % 3 != 2);
      do_pop  = (model_q.size() > 0) && bus.out_ready;
      do_push = (model_q.size() < 2);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(gold(beat_op, beat_a, beat_b));
        beat_j++;
        exp_cnt++;
      end
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (model_q.size() > 0) begin
        chk("drain_y", 32'(bus.y), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
      @(negedge clk);
    end
    chk("mix_empty", 32'(bus.out_valid), 32'd0);
    chk("mix_count", 32'(bus.xfer_count), 32'(exp_cnt));

    // async reset with two entries buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd7, 8'h81, 8'h00);
    @(negedge clk);
    drive(1'b1, 3'd6, 8'h81, 8'h00);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    chk("pre_rst_y", 32'(bus.y), 32'h81);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_y", 32'(bus.y), 32'd0);
    chk("arst_count", 32'(bus.xfer_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_release_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("arst_no_beat", 32'(bus.out_valid), 32'd0);
    chk("arst_count_hold", 32'(bus.xfer_count), 32'd0);

    // counter saturation on the CNT_W=3 instance
    bus2.in_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      chk($sformatf("sat_count_%0d", n), 32'(bus2.xfer_count), 32'((n < 7) ? n : 7));
    end
    chk("sat_y", 32'(bus2.y), 32'h11);
    bus2.in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
